// File: rtl/mdio_pkg.sv
// Shared MDIO clause-22 definitions: FSM state codes, opcodes and field widths.
// Used by both the PHY-side responder and the station-side master.
package mdio_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ST1   = 3'd1;
    localparam logic [2:0] ST_OP    = 3'd2;
    localparam logic [2:0] ST_PHYAD = 3'd3;
    localparam logic [2:0] ST_REGAD = 3'd4;
    localparam logic [2:0] ST_TA    = 3'd5;
    localparam logic [2:0] ST_DATA  = 3'd6;
    localparam logic [2:0] ST_ABORT = 3'd7;

    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    localparam int OP_W    = 2;
    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int TA_W    = 2;
    localparam int DATA_W  = 16;

endpackage

// File: rtl/mdio_edge_sync.sv
// Synchronises MDC and MDIO into clk domain and flags rising MDC edges.
// Edge is taken from the last two MDC stages; MDIO is taken from its last stage.
module mdio_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_Clk,
    input  logic i_ARst_L,
    input  logic i_Mdc,
    input  logic i_Mdio,
    output logic mdc_rise,
    output logic mdio_sync
);

    logic [SYNC_STAGES-1:0] mdc_q;
    logic [SYNC_STAGES-1:0] mdio_q;

    // Idle MDIO is pulled high, so reset the MDIO chain to 1
    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            mdc_q  <= '0;
            mdio_q <= '1;
        end else begin
            mdc_q  <= {mdc_q[SYNC_STAGES-2:0], i_Mdc};
            mdio_q <= {mdio_q[SYNC_STAGES-2:0], i_Mdio};
        end
    end

    assign mdc_rise  = mdc_q[SYNC_STAGES-2] & ~mdc_q[SYNC_STAGES-1];
    assign mdio_sync = mdio_q[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_slave_if.sv
// Clause-22 MDIO responder: decodes frames for this PHY address and strobes a register bus.
// Build option MDIO_BCAST_EN: PHY address 0 also matches, for writes only.
//
// state | meaning
// IDLE  | counting preamble ones, waiting for ST bit 0
// ST1   | expecting second start bit (1)
// OP    | shifting 2-bit opcode
// PHYAD | shifting PHY address, compared after 5th bit
// REGAD | shifting register address, read strobe on last bit
// TA    | turnaround; reads drive 0 on the second bit
// DATA  | write: shift in 16 bits; read: present 16 bits
// ABORT | release bus, clear busy and preamble, back to IDLE
module mdio_slave_if
    import mdio_pkg::*;
#(
    parameter int PREAMBLE_MIN = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        i_Clk,
    input  logic        i_ARst_L,
    input  logic        i_Mdc,
    inout  wire         io_Mdio,
    input  logic [4:0]  i5_PhyAddr,
    output logic        o_RegRdEn,
    output logic        o_RegWrEn,
    output logic [4:0]  o5_RegAddr,
    output logic [15:0] o16_RegWrData,
    input  logic [15:0] i16_RegRdData,
    output logic        o_Busy
);

    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

    logic              mdc_rise;
    logic              mdio_bit;
    logic [2:0]        state;
    logic [3:0]        bit_cnt;
    logic [5:0]        pre_cnt;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_in;
    logic [4:0]        regad_q;
    logic              is_rd;
    logic              mdio_oe;
    logic              phy_match;

    mdio_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .i_Clk     (i_Clk),
        .i_ARst_L  (i_ARst_L),
        .i_Mdc     (i_Mdc),
        .i_Mdio    (io_Mdio),
        .mdc_rise  (mdc_rise),
        .mdio_sync (mdio_bit)
    );

    assign io_Mdio  = mdio_oe ? 1'b0 : 1'bz;
    assign shift_in = {shift_q[DATA_W-2:0], mdio_bit};

`ifdef MDIO_BCAST_EN
    assign phy_match = (shift_in[4:0] == i5_PhyAddr) || (!is_rd && shift_in[4:0] == 5'd0);
`else
    assign phy_match = (shift_in[4:0] == i5_PhyAddr);
`endif

    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            pre_cnt       <= '0;
            shift_q       <= '0;
            regad_q       <= '0;
            is_rd         <= 1'b0;
            mdio_oe       <= 1'b0;
            o_RegRdEn     <= 1'b0;
            o_RegWrEn     <= 1'b0;
            o5_RegAddr    <= '0;
            o16_RegWrData <= '0;
            o_Busy        <= 1'b0;
        end else begin
            o_RegRdEn <= 1'b0;
            o_RegWrEn <= 1'b0;
            // Register file answers one cycle after the read strobe
            if (o_RegRdEn)
                shift_q <= i16_RegRdData;

            if (state == ST_ABORT) begin
                state   <= ST_IDLE;
                mdio_oe <= 1'b0;
                o_Busy  <= 1'b0;
                pre_cnt <= '0;
            end else if (mdc_rise) begin
                bit_cnt <= bit_cnt - 4'd1;
                case (state)
                    ST_IDLE: begin
                        if (mdio_bit) begin
                            if (pre_cnt < PRE_MIN)
                                pre_cnt <= pre_cnt + 6'd1;
                        end else if (pre_cnt >= PRE_MIN) begin
                            state  <= ST_ST1;
                            o_Busy <= 1'b1;
                        end else begin
                            pre_cnt <= '0;
                        end
                    end
                    ST_ST1: begin
                        if (mdio_bit) begin
                            state   <= ST_OP;
                            bit_cnt <= 4'(OP_W - 1);
                        end else begin
                            state <= ST_ABORT;
                        end
                    end
                    ST_OP: begin
                        shift_q <= shift_in;
                        if (bit_cnt == 4'd0) begin
                            is_rd <= (shift_in[1:0] == OP_RD);
                            if (shift_in[1:0] == OP_RD || shift_in[1:0] == OP_WR) begin
                                state   <= ST_PHYAD;
                                bit_cnt <= 4'(PHYAD_W - 1);
                            end else begin
                                state <= ST_ABORT;
                            end
                        end
                    end
                    ST_PHYAD: begin
                        shift_q <= shift_in;
                        if (bit_cnt == 4'd0) begin
                            if (phy_match) begin
                                state   <= ST_REGAD;
                                bit_cnt <= 4'(REGAD_W - 1);
                            end else begin
                                state <= ST_ABORT;
                            end
                        end
                    end
                    ST_REGAD: begin
                        shift_q <= shift_in;
                        if (bit_cnt == 4'd0) begin
                            regad_q <= shift_in[4:0];
                            state   <= ST_TA;
                            bit_cnt <= 4'(TA_W - 1);
                            if (is_rd) begin
                                o_RegRdEn  <= 1'b1;
                                o5_RegAddr <= shift_in[4:0];
                            end
                        end
                    end
                    ST_TA: begin
                        if (bit_cnt != 4'd0) begin
                            mdio_oe <= is_rd;
                        end else begin
                            state   <= ST_DATA;
                            bit_cnt <= 4'(DATA_W - 1);
                            if (is_rd) begin
                                mdio_oe <= ~shift_q[DATA_W-1];
                                shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    ST_DATA: begin
                        if (is_rd) begin
                            mdio_oe <= (bit_cnt == 4'd0) ? 1'b0 : ~shift_q[DATA_W-1];
                            shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                        end else begin
                            shift_q <= shift_in;
                        end
                        if (bit_cnt == 4'd0) begin
                            state   <= ST_IDLE;
                            o_Busy  <= 1'b0;
                            pre_cnt <= '0;
                            if (!is_rd) begin
                                o_RegWrEn     <= 1'b1;
                                o16_RegWrData <= shift_in;
                                o5_RegAddr    <= regad_q;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_slave_if.sv
// Directed self-checking bench for mdio_slave_if: station-side MDC/MDIO driver,
// register-file model that answers one cycle after the read strobe.
module tb_mdio_slave_if;

    localparam int HALF = 6;
`ifdef MDIO_BCAST_EN
    localparam int BCAST_WR = 1;
`else
    localparam int BCAST_WR = 0;
`endif

    logic        i_Clk = 1'b0;
    logic        i_ARst_L = 1'b0;
    logic        i_Mdc = 1'b0;
    wire         io_Mdio;
    logic [4:0]  i5_PhyAddr = 5'h03;
    logic        o_RegRdEn;
    logic        o_RegWrEn;
    logic [4:0]  o5_RegAddr;
    logic [15:0] o16_RegWrData;
    logic [15:0] i16_RegRdData;
    logic        o_Busy;

    logic        st_oe = 1'b0;
    logic        st_val = 1'b1;
    logic [15:0] reg_val = 16'hA5C3;

    int n_checks = 0;
    int n_pass = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;
    int drv_cnt = 0;
    logic [4:0]  last_wr_addr = '0;
    logic [4:0]  last_rd_addr = '0;
    logic [15:0] last_wr_data = '0;

    assign io_Mdio = st_oe ? st_val : 1'bz;
    pullup (io_Mdio);

    always #5 i_Clk = ~i_Clk;

    mdio_slave_if #(
        .PREAMBLE_MIN (32),
        .SYNC_STAGES  (2)
    ) dut (
        .i_Clk         (i_Clk),
        .i_ARst_L      (i_ARst_L),
        .i_Mdc         (i_Mdc),
        .io_Mdio       (io_Mdio),
        .i5_PhyAddr    (i5_PhyAddr),
        .o_RegRdEn     (o_RegRdEn),
        .o_RegWrEn     (o_RegWrEn),
        .o5_RegAddr    (o5_RegAddr),
        .o16_RegWrData (o16_RegWrData),
        .i16_RegRdData (i16_RegRdData),
        .o_Busy        (o_Busy)
    );

    // Register file model: valid read data only in the cycle after the strobe
    always @(negedge i_Clk) begin
        i16_RegRdData = o_RegRdEn ? reg_val : 16'hDEAD;
        if (o_RegRdEn) begin
            rd_cnt++;
            last_rd_addr = o5_RegAddr;
        end
        if (o_RegWrEn) begin
            wr_cnt++;
            last_wr_addr = o5_RegAddr;
            last_wr_data = o16_RegWrData;
        end
        if (o_RegRdEn && o_RegWrEn) both_cnt++;
        if (!st_oe && io_Mdio === 1'b0) drv_cnt++;
    end

    task automatic mdc_cycle(input logic drv, input logic val, output logic smp);
        st_oe = drv;
        st_val = val;
        repeat (HALF) @(negedge i_Clk);
        smp = io_Mdio;
        i_Mdc = 1'b1;
        repeat (HALF) @(negedge i_Clk);
        i_Mdc = 1'b0;
    endtask

    task automatic send_frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] rega, input logic [15:0] data, input int n_bits,
                              output logic [17:0] rd_bits, output logic busy_mid);
        logic [31:0] fr;
        logic smp;
        logic is_rd;
        fr = {2'b01, op, phy, rega, 2'b10, data};
        is_rd = (op == 2'b10);
        rd_bits = '0;
        busy_mid = 1'b0;
        for (int i = 0; i < pre_len; i++) mdc_cycle(1'b1, 1'b1, smp);
        for (int i = 0; i < n_bits; i++) begin
            if (is_rd && i >= 14) mdc_cycle(1'b0, 1'b1, smp);
            else mdc_cycle(1'b1, fr[31-i], smp);
            if (i >= 14) rd_bits = {rd_bits[16:0], smp};
            if (i == 2) busy_mid = o_Busy;
        end
        st_oe = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++; if (o_RegRdEn !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", o_RegRdEn); else n_pass++;
        n_checks++; if (o_RegWrEn !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", o_RegWrEn); else n_pass++;
        n_checks++; if (o5_RegAddr !== 5'h00) $display("FAIL reset_addr: got %h want 00", o5_RegAddr); else n_pass++;
        n_checks++; if (o16_RegWrData !== 16'h0000) $display("FAIL reset_wdata: got %h want 0000", o16_RegWrData); else n_pass++;
        n_checks++; if (o_Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_Busy); else n_pass++;
        n_checks++; if (io_Mdio !== 1'b1) $display("FAIL reset_mdio: got %b want released(1)", io_Mdio); else n_pass++;
    endtask

    task automatic test_write;
        int w0, r0;
        logic [17:0] rb;
        logic bm;
        w0 = wr_cnt; r0 = rd_cnt;
        send_frame(32, 2'b01, 5'h03, 5'h04, 16'h1234, 32, rb, bm);
        n_checks++; if (wr_cnt - w0 !== 1) $display("FAIL wr_count: got %0d want 1", wr_cnt - w0); else n_pass++;
        n_checks++; if (last_wr_addr !== 5'h04) $display("FAIL wr_addr: got %h want 04", last_wr_addr); else n_pass++;
        n_checks++; if (last_wr_data !== 16'h1234) $display("FAIL wr_data: got %h want 1234", last_wr_data); else n_pass++;
        n_checks++; if (rd_cnt - r0 !== 0) $display("FAIL wr_no_rd: got %0d want 0", rd_cnt - r0); else n_pass++;
        n_checks++; if (bm !== 1'b1) $display("FAIL wr_busy_mid: got %b want 1", bm); else n_pass++;
        n_checks++; if (o_Busy !== 1'b0) $display("FAIL wr_busy_end: got %b want 0", o_Busy); else n_pass++;
    endtask

    task automatic test_read;
        int w0, r0;
        logic [17:0] rb;
        logic bm;
        w0 = wr_cnt; r0 = rd_cnt;
        reg_val = 16'hA5C3;
        send_frame(32, 2'b10, 5'h03, 5'h02, 16'h0000, 32, rb, bm);
        repeat (2) @(negedge i_Clk);
        n_checks++; if (rd_cnt - r0 !== 1) $display("FAIL rd_count: got %0d want 1", rd_cnt - r0); else n_pass++;
        n_checks++; if (last_rd_addr !== 5'h02) $display("FAIL rd_addr: got %h want 02", last_rd_addr); else n_pass++;
        n_checks++; if (rb !== {1'b1, 1'b0, 16'hA5C3}) $display("FAIL rd_bits: got %h want %h", rb, {1'b1, 1'b0, 16'hA5C3}); else n_pass++;
        n_checks++; if (wr_cnt - w0 !== 0) $display("FAIL rd_no_wr: got %0d want 0", wr_cnt - w0); else n_pass++;
        n_checks++; if (io_Mdio !== 1'b1) $display("FAIL rd_release: got %b want 1", io_Mdio); else n_pass++;
        // Second read ends in D0=0 so a missing release is visible
        reg_val = 16'h3C5A;
        send_frame(32, 2'b10, 5'h03, 5'h1F, 16'h0000, 32, rb, bm);
        repeat (2) @(negedge i_Clk);
        n_checks++; if (rb !== {1'b1, 1'b0, 16'h3C5A}) $display("FAIL rd2_bits: got %h want %h", rb, {1'b1, 1'b0, 16'h3C5A}); else n_pass++;
        n_checks++; if (io_Mdio !== 1'b1) $display("FAIL rd2_release: got %b want 1", io_Mdio); else n_pass++;
        n_checks++; if (o_Busy !== 1'b0) $display("FAIL rd2_busy_end: got %b want 0", o_Busy); else n_pass++;
    endtask

    task automatic test_mismatch;
        int w0, r0, d0;
        logic [17:0] rb;
        logic bm;
        w0 = wr_cnt; r0 = rd_cnt; d0 = drv_cnt;
        send_frame(32, 2'b01, 5'h07, 5'h04, 16'h5555, 32, rb, bm);
        send_frame(32, 2'b10, 5'h07, 5'h04, 16'h0000, 32, rb, bm);
        n_checks++; if (wr_cnt - w0 !== 0) $display("FAIL mm_wr: got %0d want 0", wr_cnt - w0); else n_pass++;
        n_checks++; if (rd_cnt - r0 !== 0) $display("FAIL mm_rd: got %0d want 0", rd_cnt - r0); else n_pass++;
        n_checks++; if (drv_cnt - d0 !== 0) $display("FAIL mm_drive: got %0d want 0", drv_cnt - d0); else n_pass++;
        n_checks++; if (o_Busy !== 1'b0) $display("FAIL mm_busy: got %b want 0", o_Busy); else n_pass++;
        send_frame(32, 2'b01, 5'h03, 5'h0A, 16'hC0DE, 32, rb, bm);
        n_checks++; if (wr_cnt - w0 !== 1) $display("FAIL mm_follow_wr: got %0d want 1", wr_cnt - w0); else n_pass++;
        n_checks++; if (last_wr_data !== 16'hC0DE) $display("FAIL mm_follow_data: got %h want c0de", last_wr_data); else n_pass++;
    endtask

    task automatic test_bad_frames;
        int w0, r0;
        logic [17:0] rb;
        logic bm;
        w0 = wr_cnt; r0 = rd_cnt;
        send_frame(31, 2'b01, 5'h03, 5'h04, 16'h1234, 32, rb, bm);
        n_checks++; if (wr_cnt - w0 !== 0) $display("FAIL short_pre_wr: got %0d want 0", wr_cnt - w0); else n_pass++;
        n_checks++; if (bm !== 1'b0) $display("FAIL short_pre_busy: got %b want 0", bm); else n_pass++;
        send_frame(32, 2'b11, 5'h03, 5'h04, 16'h1234, 32, rb, bm);
        n_checks++; if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) $display("FAIL op11_strobe: got wr %0d rd %0d want 0 0", wr_cnt - w0, rd_cnt - r0); else n_pass++;
        n_checks++; if (o_Busy !== 1'b0) $display("FAIL op11_busy: got %b want 0", o_Busy); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int w0;
        logic [17:0] rb;
        logic bm;
        w0 = wr_cnt;
        send_frame(32, 2'b01, 5'h03, 5'h05, 16'h1111, 32, rb, bm);
        send_frame(0, 2'b01, 5'h03, 5'h06, 16'h2222, 32, rb, bm);
        n_checks++; if (wr_cnt - w0 !== 1) $display("FAIL b2b_count: got %0d want 1", wr_cnt - w0); else n_pass++;
        n_checks++; if (last_wr_addr !== 5'h05 || last_wr_data !== 16'h1111) $display("FAIL b2b_first: got %h/%h want 05/1111", last_wr_addr, last_wr_data); else n_pass++;
        n_checks++; if (both_cnt !== 0) $display("FAIL strobe_overlap: got %0d want 0", both_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_read;
        int w0;
        logic [17:0] rb;
        logic bm;
        reg_val = 16'h5AC3;
        // Stop after the edge sampling D9, while D8 (0) is being driven
        send_frame(32, 2'b10, 5'h03, 5'h02, 16'h0000, 23, rb, bm);
        n_checks++; if (io_Mdio !== 1'b0) $display("FAIL mid_d8_driven: got %b want 0", io_Mdio); else n_pass++;
        i_ARst_L = 1'b0;
        #1;
        n_checks++; if (io_Mdio !== 1'b1) $display("FAIL mid_rst_release: got %b want 1", io_Mdio); else n_pass++;
        n_checks++; if (o_Busy !== 1'b0 || o5_RegAddr !== 5'h00 || o16_RegWrData !== 16'h0000 || o_RegRdEn !== 1'b0 || o_RegWrEn !== 1'b0)
            $display("FAIL mid_rst_outputs: got busy %b addr %h wdata %h rd %b wr %b want all 0", o_Busy, o5_RegAddr, o16_RegWrData, o_RegRdEn, o_RegWrEn);
        else n_pass++;
        @(negedge i_Clk);
        i_ARst_L = 1'b1;
        repeat (3) @(negedge i_Clk);
        w0 = wr_cnt;
        send_frame(32, 2'b01, 5'h03, 5'h09, 16'hBEEF, 32, rb, bm);
        n_checks++; if (wr_cnt - w0 !== 1 || last_wr_data !== 16'hBEEF || last_wr_addr !== 5'h09)
            $display("FAIL post_rst_wr: got cnt %0d %h/%h want 1 09/beef", wr_cnt - w0, last_wr_addr, last_wr_data);
        else n_pass++;
    endtask

    task automatic test_bcast;
        int w0, r0, d0;
        logic [17:0] rb;
        logic bm;
        w0 = wr_cnt; r0 = rd_cnt; d0 = drv_cnt;
        send_frame(32, 2'b01, 5'h00, 5'h0C, 16'h0BCA, 32, rb, bm);
        n_checks++; if (wr_cnt - w0 !== BCAST_WR) $display("FAIL bcast_wr: got %0d want %0d", wr_cnt - w0, BCAST_WR); else n_pass++;
        send_frame(32, 2'b10, 5'h00, 5'h0C, 16'h0000, 32, rb, bm);
        n_checks++; if (rd_cnt - r0 !== 0) $display("FAIL bcast_rd: got %0d want 0", rd_cnt - r0); else n_pass++;
        n_checks++; if (drv_cnt - d0 !== 0) $display("FAIL bcast_drive: got %0d want 0", drv_cnt - d0); else n_pass++;
        n_checks++; if (o_Busy !== 1'b0) $display("FAIL bcast_busy: got %b want 0", o_Busy); else n_pass++;
    endtask

    initial begin
        repeat (3) @(negedge i_Clk);
        test_reset;
        i_ARst_L = 1'b1;
        repeat (3) @(negedge i_Clk);
        test_write;
        test_read;
        test_mismatch;
        test_bad_frames;
        test_back_to_back;
        test_reset_mid_read;
        test_bcast;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdio_slave_if.md
Name: mdio_slave_if

Overview:
- Clause-22 MDIO responder (PHY side) for the SGMII core's management plane.
- Oversamples an external MDC/MDIO pair on the system clock and decodes read/write frames addressed to its PHY address.
- Presents a single-cycle register-bus strobe to a local register file.
- On reads, drives turnaround and data open-drain onto MDIO.

Parameters:
- PREAMBLE_MIN, 32: consecutive 1-bits required before ST is accepted (1..32).
- SYNC_STAGES, 2: synchroniser depth on MDC and MDIO inputs (2..3).

Ports:
- i_Clk  in  1  system clock; all logic on rising edge.
- i_ARst_L  in  1  asynchronous active-low reset.
- i_Mdc  in  1  management clock from station; asynchronous to i_Clk.
- io_Mdio  inout  1  management data, open-drain: driven 0 or released (z), never driven 1.
- i5_PhyAddr  in  5  this PHY's address; static while a frame is in progress.
- o_RegRdEn  out  1  one-cycle read strobe.
- o_RegWrEn  out  1  one-cycle write strobe.
- o5_RegAddr  out  5  register address; valid with either strobe.
- o16_RegWrData  out  16  write data; valid with o_RegWrEn.
- i16_RegRdData  in  16  read data; sampled exactly 1 i_Clk after o_RegRdEn.
- o_Busy  out  1  high from ST accepted until return to IDLE.

Behaviour:
- Reset: o_RegRdEn=0, o_RegWrEn=0, o5_RegAddr=0, o16_RegWrData=0, o_Busy=0, io_Mdio released, state=IDLE, preamble count=0.
- Input conditioning:
  - MDC and MDIO pass through SYNC_STAGES flops.
  - A rising MDC edge is detected from the last two MDC stages.
  - All bit sampling and all output updates happen on detected rising edges only.
  - Requirement: MDC high and low phases each >= SYNC_STAGES+2 i_Clk.
- Bit sampled = synchronised MDIO at the detected rising edge.
- FSM states and transitions (bit counter reloaded on every state entry):
  - IDLE: sampled 1 -> preamble count +1, saturating at PREAMBLE_MIN. Sampled 0 with count >= PREAMBLE_MIN -> ST1, o_Busy=1. Sampled 0 with count < PREAMBLE_MIN -> count=0.
  - ST1: sampled 1 -> OP; sampled 0 -> ABORT.
  - OP (2 bits): 10=read, 01=write, 00/11 -> ABORT.
  - PHYAD (5 bits, MSB first): mismatch with i5_PhyAddr -> ABORT after the 5th bit.
  - REGAD (5 bits): on completing a read, assert o_RegRdEn for 1 i_Clk with o5_RegAddr; capture i16_RegRdData into the shift register on the next i_Clk.
  - TA (2 bits): not checked on writes.
  - DATA (16 bits, MSB first):
    - Write: after the 16th bit, o16_RegWrData and o5_RegAddr update and o_RegWrEn pulses 1 i_Clk in the same cycle.
    - Read: the block drives data; bits it samples are discarded.
  - Then IDLE.
  - ABORT: release MDIO, clear o_Busy and preamble count, go to IDLE.
- Read drive timing, each step at a detected rising edge:
  - Edge sampling last REGAD bit: stay released (TA bit 1 = Z).
  - Edge sampling TA bit 1: drive 0.
  - Edge sampling TA bit 2: present D15.
  - Each following edge: next bit.
  - Edge after D0: release.
  - Bit value 1 = released.
- Every frame requires a fresh preamble: the preamble count clears on frame completion and on abort.
- Bus-side ordering: strobes are never simultaneous; the register file must accept a strobe every cycle.
- Reset mid-frame: immediate release of MDIO and return to reset state; the partial frame produces no strobe.
- MDC stopped mid-frame: FSM holds its state indefinitely; there is no timeout.

Optional Feature:
- MDIO_BCAST_EN defined: PHYAD 00000 also matches, for writes only. A broadcast read aborts after PHYAD, so there is no bus contention.
- Undefined: only an exact match with i5_PhyAddr matches.

Decomposition:
- Shared package mdio_pkg:
  - FSM state encodings (IDLE, ST1, OP, PHYAD, REGAD, TA, DATA, ABORT).
  - Opcode constants OP_RD=2'b10, OP_WR=2'b01.
  - Field widths (PHYAD/REGAD=5, DATA=16).
  - Shared with the MDIO master for consistency.
- Sub-module mdio_edge_sync: synchroniser plus rising-edge detector for MDC, and synchroniser for MDIO. It is reused by both master and slave bench monitors.

Test Plan:
- Write: 32 ones, then ST01 OP01 PHYAD=i5_PhyAddr=5'h03 REGAD=5'h04 TA10 data 16'h1234 -> exactly one o_RegWrEn pulse with o5_RegAddr=4 and o16_RegWrData=16'h1234; o_Busy falls after the data.
- Read: 32 ones, then OP10 PHYAD=3 REGAD=5'h02, register returns 16'hA5C3 -> one o_RegRdEn with addr 2; MDIO reads Z,0 in TA, then 1010010111000011; released after D0.
- Address mismatch: PHYAD=5'h07 with i5_PhyAddr=3 -> no strobes, MDIO never driven, and a following valid frame is accepted.
- Short preamble and bad frames:
  - 31 ones then a frame -> ignored.
  - OP=11 -> abort, no strobe.
  - Two back-to-back frames with no preamble between -> the second is ignored.
- Reset mid-read during D8 -> MDIO released the same cycle and all outputs at reset values; the next full frame works.
- MDIO_BCAST_EN:
  - Write to PHYAD 0 -> strobe when defined, none when undefined.
  - Read to PHYAD 0 -> never driven in either build.
